window_sum_arbiter: RTL and testbench

//  Shares one sliding-window sum datapath (sum of last 2*N samples) between NUM_REQ requesters.

---
 rtl/window_sum_arbiter_pkg.sv | 22 ++
 rtl/window_sum_arbiter_if.sv | 35 +++
 rtl/window_sum_arbiter_rr_arbiter.sv | 33 +++
 rtl/window_sum_arbiter.sv | 126 ++++++++++++
 tb/tb_window_sum_arbiter.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/window_sum_arbiter_pkg.sv
// Purpose : shared defaults and sizing helpers for the window-sum arbiter slice.
// Latency : n/a (package only).
// Backpressure: n/a.
// Contents: DEF_DATA_WIDTH / DEF_N / DEF_NUM_REQ defaults, WIN (window length),
//           id_w() (clog2 with a minimum of 1), win_len().
package window_sum_pkg;

  localparam int DEF_DATA_WIDTH = 10;
  localparam int DEF_N          = 4;
  localparam int DEF_NUM_REQ    = 2;
  localparam int WIN            = 2 * DEF_N;

  // Encoded requester id width; a single-bit id is kept even for tiny configs.
  function automatic int id_w(input int num_req);
    return (num_req <= 2) ? 1 : $clog2(num_req);
  endfunction

  function automatic int win_len(input int n);
    return 2 * n;
  endfunction

endpackage

// File: rtl/window_sum_arbiter_if.sv
// Purpose : request/result bundle between sample producers, the arbiter and sum consumers.
// Latency : n/a (wiring only).
// Backpressure: per-requester ready on the request side; result side has none.
// Ports   : clr, req_valid/req_data (producer -> arbiter), req_ready (arbiter -> producer),
//           out_valid/out_id/out_sum/out_primed (arbiter -> consumer).
interface window_sum_arbiter_if
  import window_sum_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int ID_W       = id_w(DEF_NUM_REQ)
);

  logic                          clr;
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          out_valid;
  logic [ID_W-1:0]               out_id;
  logic [DATA_WIDTH-1:0]         out_sum;
  logic                          out_primed;

  // Producer/consumer side.
  modport master (
    output clr, req_valid, req_data,
    input  req_ready, out_valid, out_id, out_sum, out_primed
  );

  // Arbiter side.
  modport slave (
    input  clr, req_valid, req_data,
    output req_ready, out_valid, out_id, out_sum, out_primed
  );

endinterface

// File: rtl/window_sum_arbiter_rr_arbiter.sv
// Purpose : round-robin pick of one request, search starting at ptr and wrapping.
// Latency : combinational.
// Backpressure: none; losers simply see gnt=0.
// Ports   : req (request vector), ptr (highest-priority index) -> gnt (one-hot),
//           gnt_id (encoded), gnt_any (some request granted).
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id,
  output logic               gnt_any
);

  always_comb begin
    int idx;
    gnt     = '0;
    gnt_id  = '0;
    gnt_any = 1'b0;
    idx     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!gnt_any && req[idx]) begin
        gnt_any  = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/window_sum_arbiter.sv
// Purpose : one shared sliding-window (2*N samples) sum datapath time-shared by NUM_REQ requesters.
// Latency : 1 cycle from acceptance to out_valid pulse carrying that requester's new sum.
// Backpressure: only non-granted requesters stall; no output backpressure (consumer takes every pulse).
// Ports   : clk, rst (sync, active-high), bus (slave modport: clr, req_*, out_*).
module window_sum_arbiter
  import window_sum_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int N          = DEF_N,
  parameter int NUM_REQ    = DEF_NUM_REQ
) (
  input  logic                clk,
  input  logic                rst,
  window_sum_arbiter_if.slave bus
);

  localparam int W_LEN  = win_len(N);
  localparam int ID_W   = id_w(NUM_REQ);
  localparam int FILL_W = $clog2(W_LEN + 1);

  logic [ID_W-1:0]       ptr;
  logic [NUM_REQ-1:0]    req_elig;
  logic [NUM_REQ-1:0]    gnt;
  logic [ID_W-1:0]       gnt_id;
  logic                  gnt_any;

  // hist[i][0] is the newest sample, hist[i][W_LEN-1] the one about to drop out.
  logic [DATA_WIDTH-1:0] hist [NUM_REQ][W_LEN];
  logic [DATA_WIDTH-1:0] sum  [NUM_REQ];
  logic [FILL_W-1:0]     fill [NUM_REQ];

  logic [DATA_WIDTH-1:0] sel_data;
  logic [DATA_WIDTH-1:0] sel_sum;
  logic [DATA_WIDTH-1:0] sel_old;
  logic [FILL_W-1:0]     sel_fill;
  logic [DATA_WIDTH-1:0] new_sum;
  logic [FILL_W-1:0]     fill_nxt;
  logic [ID_W-1:0]       ptr_nxt;

  logic                  out_valid_q;
  logic [ID_W-1:0]       out_id_q;
  logic [DATA_WIDTH-1:0] out_sum_q;
  logic                  out_primed_q;

  // Nothing is granted while the state is being wiped, so no sample is lost.
  assign req_elig = (rst || bus.clr) ? '0 : bus.req_valid;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_arbiter (
    .req     (req_elig),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .gnt_any (gnt_any)
  );

  assign bus.req_ready = gnt;

  // One-hot mux feeding the single shared add/subtract.
  always_comb begin
    sel_data = '0;
    sel_sum  = '0;
    sel_old  = '0;
    sel_fill = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_data = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
        sel_sum  = sum[i];
        sel_old  = hist[i][W_LEN-1];
        sel_fill = fill[i];
      end
    end
  end

  // Empty slots hold 0, so warm-up needs no special case; wrap is modulo 2**DATA_WIDTH.
  assign new_sum  = sel_sum + sel_data - sel_old;
  assign fill_nxt = (sel_fill == FILL_W'(W_LEN)) ? sel_fill : sel_fill + FILL_W'(1);
  assign ptr_nxt  = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + ID_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        for (int j = 0; j < W_LEN; j++) hist[i][j] <= '0;
        sum[i]  <= '0;
        fill[i] <= '0;
      end
      ptr          <= '0;
      out_valid_q  <= 1'b0;
      out_id_q     <= '0;
      out_sum_q    <= '0;
      out_primed_q <= 1'b0;
    end else if (bus.clr) begin
      // Pointer deliberately survives a clear to keep fairness across it.
      for (int i = 0; i < NUM_REQ; i++) begin
        for (int j = 0; j < W_LEN; j++) hist[i][j] <= '0;
        sum[i]  <= '0;
        fill[i] <= '0;
      end
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= gnt_any;
      if (gnt_any) begin
        ptr          <= ptr_nxt;
        out_id_q     <= gnt_id;
        out_sum_q    <= new_sum;
        out_primed_q <= (fill_nxt == FILL_W'(W_LEN));
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (gnt[i]) begin
          for (int j = W_LEN - 1; j > 0; j--) hist[i][j] <= hist[i][j-1];
          hist[i][0] <= sel_data;
          sum[i]     <= new_sum;
          fill[i]    <= fill_nxt;
        end
      end
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_id     = out_id_q;
  assign bus.out_sum    = out_sum_q;
  assign bus.out_primed = out_primed_q;

endmodule

// File: tb/tb_window_sum_arbiter.sv
// Purpose : randomized + directed self-check of window_sum_arbiter (NUM_REQ=2 and NUM_REQ=3 instances).
// Latency : expects result pulse one cycle after each accept.
// Backpressure: producers hold requests until granted; reference model decides grants.
module tb_window_sum_arbiter;
  import window_sum_pkg::*;

  localparam int DW   = 10;
  localparam int NN   = 4;
  localparam int WL   = 2 * NN;
  localparam int LOGN = 1024;

  logic tb_clk = 1'b0;
  always #5 tb_clk = ~tb_clk;

  logic rst2, rst3;

  window_sum_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(2), .ID_W(1)) i2 ();
  window_sum_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(3), .ID_W(2)) i3 ();

  window_sum_arbiter #(.DATA_WIDTH(DW), .N(NN), .NUM_REQ(2)) dut2 (
    .clk (tb_clk),
    .rst (rst2),
    .bus (i2.slave)
  );

  window_sum_arbiter #(.DATA_WIDTH(DW), .N(NN), .NUM_REQ(3)) dut3 (
    .clk (tb_clk),
    .rst (rst3),
    .bus (i3.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: per-requester log of every accepted sample since rst/clr.
  int m_ptr [2];
  int m_cnt [2][3];
  int m_log [2][3][LOGN];

  function automatic int m_nreq(input int d);
    return (d == 0) ? 2 : 3;
  endfunction

  function automatic int m_sum(input int d, input int r);
    int s, lo;
    s  = 0;
    lo = m_cnt[d][r] - WL;
    if (lo < 0) lo = 0;
    for (int k = lo; k < m_cnt[d][r]; k++) s += m_log[d][r][k];
    return s % (1 << DW);
  endfunction

  function automatic logic [29:0] pk(input int a, input int b, input int c);
    return {10'(c), 10'(b), 10'(a)};
  endfunction

  logic            last_valid;
  int              last_id;
  logic [DW-1:0]   last_sum;
  logic            last_primed;

  task automatic step(input int d, input logic [2:0] v, input logic [29:0] dat,
                      input logic c, input logic r);
    int n, g, idx;
    logic [2:0] exp_g, obs_g;
    logic o_v, o_p;
    int o_id;
    logic [DW-1:0] o_s;
    n = m_nreq(d);
    @(negedge tb_clk);
    if (d == 0) begin
      i2.req_valid = v[1:0]; i2.req_data = dat[19:0]; i2.clr = c; rst2 = r;
      i3.req_valid = '0;     i3.clr = 1'b0;           rst3 = 1'b0;
    end else begin
      i3.req_valid = v;      i3.req_data = dat;       i3.clr = c; rst3 = r;
      i2.req_valid = '0;     i2.clr = 1'b0;           rst2 = 1'b0;
    end
    g = -1;
    if (!r && !c) begin
      for (int k = 0; k < n; k++) begin
        idx = (m_ptr[d] + k) % n;
        if (g < 0 && v[idx]) g = idx;
      end
    end
    exp_g = (g >= 0) ? 3'(1 << g) : 3'b000;
    #1;
    obs_g = (d == 0) ? {1'b0, i2.req_ready} : i3.req_ready;
    check_eq("req_ready", 32'(obs_g), 32'(exp_g));
    @(posedge tb_clk);
    #1;
    if (r) begin
      m_ptr[d] = 0;
      for (int q = 0; q < 3; q++) m_cnt[d][q] = 0;
    end else if (c) begin
      for (int q = 0; q < 3; q++) m_cnt[d][q] = 0;
    end else if (g >= 0) begin
      if (m_cnt[d][g] < LOGN) begin
        m_log[d][g][m_cnt[d][g]] = int'(dat[g*DW +: DW]);
        m_cnt[d][g]++;
      end
      m_ptr[d] = (g + 1) % n;
    end
    if (d == 0) begin
      o_v = i2.out_valid; o_id = int'(i2.out_id); o_s = i2.out_sum; o_p = i2.out_primed;
    end else begin
      o_v = i3.out_valid; o_id = int'(i3.out_id); o_s = i3.out_sum; o_p = i3.out_primed;
    end
    check_eq("out_valid", 32'(o_v), 32'(g >= 0));
    if (r) begin
      check_eq("rst_out_id", 32'(o_id), 32'd0);
      check_eq("rst_out_sum", 32'(o_s), 32'd0);
      check_eq("rst_out_primed", 32'(o_p), 32'd0);
    end
    if (g >= 0) begin
      check_eq("out_id", 32'(o_id), 32'(g));
      check_eq("out_sum", 32'(o_s), 32'(m_sum(d, g)));
      check_eq("out_primed", 32'(o_p), 32'(m_cnt[d][g] >= WL));
    end
    last_valid  = o_v;
    last_id     = o_id;
    last_sum    = o_s;
    last_primed = o_p;
  endtask

  int t1_exp [9] = '{1, 3, 6, 10, 15, 21, 28, 36, 44};
  int s_by_id [3];
  int prev_id;

  initial begin
    rst2 = 1'b1; rst3 = 1'b1;
    i2.clr = 1'b0; i2.req_valid = '0; i2.req_data = '0;
    i3.clr = 1'b0; i3.req_valid = '0; i3.req_data = '0;
    for (int d = 0; d < 2; d++) begin
      m_ptr[d] = 0;
      for (int q = 0; q < 3; q++) m_cnt[d][q] = 0;
    end

    // Reset state, and no grant while rst is high even with requests pending.
    step(0, 3'b000, '0, 1'b0, 1'b1);
    step(1, 3'b000, '0, 1'b0, 1'b1);
    step(0, 3'b011, pk(3, 4, 0), 1'b0, 1'b1);

    // Warm-up, priming and first eviction on req0.
    for (int k = 1; k <= 9; k++) begin
      step(0, 3'b001, pk(k, 0, 0), 1'b0, 1'b0);
      check_eq("t1_sum", 32'(last_sum), 32'(t1_exp[k-1]));
      check_eq("t1_primed", 32'(last_primed), 32'(k >= 8));
    end

    // clr while both valid: nothing granted, no pulse next cycle.
    step(0, 3'b011, pk(1, 100, 0), 1'b1, 1'b0);
    check_eq("t4_clr_valid", 32'(last_valid), 32'd0);

    // Both valid every cycle: strict alternation, 8 samples each.
    prev_id = -1;
    for (int k = 0; k < 16; k++) begin
      step(0, 3'b011, pk(1, 100, 0), 1'b0, 1'b0);
      if (prev_id >= 0) check_eq("t2_alt", 32'(last_id), 32'(1 - prev_id));
      prev_id = last_id;
      s_by_id[last_id] = int'(last_sum);
    end
    check_eq("t2_sum0", 32'(s_by_id[0]), 32'd8);
    check_eq("t2_sum1", 32'(s_by_id[1]), 32'd800);

    // Modulo wrap.
    step(0, 3'b000, '0, 1'b1, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      step(0, 3'b001, pk(1000, 0, 0), 1'b0, 1'b0);
      if (k >= 9) check_eq("t3_wrap", 32'(last_sum), 32'd832);
    end

    // After clr the history restarts from scratch.
    step(0, 3'b011, pk(2, 2, 0), 1'b1, 1'b0);
    step(0, 3'b001, pk(5, 0, 0), 1'b0, 1'b0);
    check_eq("t4_sum", 32'(last_sum), 32'd5);
    check_eq("t4_primed", 32'(last_primed), 32'd0);

    // rst mid-stream resets the pointer too.
    for (int k = 0; k < 6; k++)
      step(0, 3'b011, pk(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)), 0), 1'b0, 1'b0);
    step(0, 3'b011, pk(1, 1, 0), 1'b0, 1'b1);
    check_eq("t5_rst_valid", 32'(last_valid), 32'd0);
    check_eq("t5_rst_sum", 32'(last_sum), 32'd0);
    step(0, 3'b011, pk(7, 9, 0), 1'b0, 1'b0);
    check_eq("t5_first_id", 32'(last_id), 32'd0);
    check_eq("t5_first_sum", 32'(last_sum), 32'd7);

    // NUM_REQ=3: lone req2 gets every cycle, then pointer wraps back to req0.
    step(1, 3'b000, '0, 1'b0, 1'b1);
    for (int k = 0; k < 10; k++) begin
      step(1, 3'b100, pk(0, 0, k + 1), 1'b0, 1'b0);
      check_eq("t6_busy", 32'(last_valid), 32'd1);
    end
    step(1, 3'b101, pk(11, 0, 12), 1'b0, 1'b0);
    check_eq("t6_wrap_id", 32'(last_id), 32'd0);

    // Randomized traffic on both instances.
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 200; k++) begin
        step(d, 3'($urandom), 30'($urandom), ($urandom % 20) == 0, ($urandom % 60) == 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
